fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Parametrised instruction-fetch front end: a program counter, a request interface to a
//   1-cycle-latency synchronous instruction memory, and a prefetch FIFO of DEPTH entries.
//   Delivers {instr, pc} pairs to decode over a valid/ready handshake.
//   Supports branch/jump redirect with flush of all stale fetches, and decode backpressure.
//   Sits between the instruction memory and the register file / decode stage.
// PARAMETERS
//   ADDR_W   9   width of PC and instruction-memory address
//   INSTR_W  32  instruction width
//   PC_STEP  1   PC increment per sequential fetch (word addressing)
//   RESET_PC 0   PC value loaded on reset
//   DEPTH    4   prefetch FIFO entries; power of 2, >= 2 (>= 4 for full throughput)
// PORTS
//   clock        in   1              system clock, rising edge
//   r            in   1              asynchronous active-low reset
//   imem_req     out  1              fetch request this cycle
//   imem_addr    out  ADDR_W         fetch address (current PC)
//   imem_data    in   INSTR_W        instruction; valid the cycle after imem_req
//   redirect     in   1              load new PC and flush, sampled at rising edge
//   redirect_pc  in   ADDR_W         target PC for redirect
//   out_valid    out  1              FIFO head holds a valid instruction
//   out_ready    in   1              decode accepts the head this cycle
//   out_instr    out  INSTR_W        head instruction (0 when out_valid=0)
//   out_pc       out  ADDR_W         PC of head instruction (0 when out_valid=0)
//   fifo_count   out  $clog2(DEPTH)+1  occupied FIFO entries
// BEHAVIOUR
//   - Reset (r=0, async): pc=RESET_PC, count=0, rd/wr ptr=0, inflight=0, drop=0;
//     imem_req=0 while r=0; out_valid=0, out_instr=0, out_pc=0, fifo_count=0.
//   - imem_req = (count + inflight) < DEPTH, combinational from registered state only
//     (no combinational path from redirect/out_ready). imem_addr = pc.
//   - On a request edge: pc <= pc + PC_STEP (mod 2^ADDR_W, wraps to 0); req_pc <= pc;
//     inflight <= 1. Otherwise inflight <= 0.
//   - Response cycle (inflight=1): if drop=0, push {imem_data, req_pc} into FIFO;
//     if drop=1, discard. Credit rule guarantees push never overflows.
//   - Pop: out_valid & out_ready at an edge advances rd_ptr. Pop while empty is impossible
//     (out_valid=0). Simultaneous push and pop: count unchanged, both pointers advance.
//   - Redirect at edge: FIFO flushed (count=0, ptrs=0), pc <= redirect_pc, inflight
//     response arriving that cycle discarded, drop <= imem_req (kills the response in the
//     next cycle); a pop handshaken in the same cycle is still counted as accepted.
//     First fetch from redirect_pc issues the cycle after redirect. Redirect dominates pc
//     increment.
//   - drop clears after one cycle unless redirect is asserted again.
//   - Latency: request in cycle N -> out_valid in cycle N+2. Sustained 1 instr/cycle
//     with out_ready=1 when DEPTH >= 4.
//   - out_ready=0: FIFO fills to DEPTH, then imem_req=0; no instruction lost or duplicated;
//     fetch resumes one cycle after credit frees.
//   - Reset asserted mid-operation: all state cleared immediately, pending response ignored.
// TESTING
//   1. Reset release, imem[k]=k+100, out_ready=1 -> imem_addr 0,1,2..., out_valid from
//      cycle 2, out_instr 100,101,102... with out_pc 0,1,2..., one per cycle.
//   2. out_ready=0 for 10 cycles -> fifo_count saturates at 4, imem_req=0; on release
//      instructions resume in strict PC order, no gaps or repeats.
//   3. redirect=1, redirect_pc=9'h040 while FIFO holds 3 -> next out_pc=0x040 after
//      2 cycles; no instruction from old path appears; fifo_count=0 right after edge.
//   4. Back-to-back redirects to 0x010 then 0x020 -> only 0x020 stream delivered.
//   5. pc=9'h1FF sequential fetch -> next out_pc 0x1FF then 0x000 (wrap).
//   6. r pulsed low mid-stream, async to clock -> outputs 0 immediately; after release
//      fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_if.sv
// Bundles the instruction-memory request/response, redirect and decode-side
// handshake signals of the fetch front end.
interface fetch_if #(
  parameter int ADDR_W  = 9,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic [CNT_W-1:0]   fifo_count;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc, fifo_count,
    input  imem_data, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, fifo_count,
    output imem_data, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, 1-cycle-latency imem requests and a prefetch
// FIFO delivering {instr, pc} to decode, with redirect flush and backpressure.
module fetch_unit #(
  parameter int ADDR_W   = 9,
  parameter int INSTR_W  = 32,
  parameter int PC_STEP  = 1,
  parameter int RESET_PC = 0,
  parameter int DEPTH    = 4
) (
  input  logic     clock,
  input  logic     r,
  fetch_if.master  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] RESET_PC_C = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] STEP_C     = ADDR_W'(PC_STEP);
  localparam logic [CNT_W:0]    DEPTH_C    = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0]  pc_r, pc_n_s;
  logic [ADDR_W-1:0]  req_pc_r, req_pc_n_s;
  logic               inflight_r, inflight_n_s;
  logic               drop_r, drop_n_s;
  logic [CNT_W-1:0]   count_r, count_n_s;
  logic [PTR_W-1:0]   rd_ptr_r, rd_ptr_n_s;
  logic [PTR_W-1:0]   wr_ptr_r, wr_ptr_n_s;
  logic [INSTR_W-1:0] instr_mem_r [DEPTH];
  logic [ADDR_W-1:0]  pc_mem_r    [DEPTH];

  logic [CNT_W:0]     occupancy_s;
  logic               imem_req_s;
  logic               push_s;
  logic               pop_s;
  logic               valid_s;

  // Credit check: queued plus in-flight fetches must leave room for one more.
  always_comb begin
    occupancy_s = {1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r};
    imem_req_s  = r & (occupancy_s < DEPTH_C);
    valid_s     = (count_r != {CNT_W{1'b0}});
    push_s      = inflight_r & ~drop_r & ~bus.redirect;
    pop_s       = valid_s & bus.out_ready;
  end

  // Next-state for PC, FIFO bookkeeping and the drop-after-redirect flag.
  always_comb begin
    pc_n_s       = pc_r;
    req_pc_n_s   = req_pc_r;
    inflight_n_s = imem_req_s;
    drop_n_s     = 1'b0;
    count_n_s    = count_r;
    rd_ptr_n_s   = rd_ptr_r;
    wr_ptr_n_s   = wr_ptr_r;

    if (imem_req_s) begin
      req_pc_n_s = pc_r;
    end else begin
      req_pc_n_s = req_pc_r;
    end

    if (bus.redirect) begin
      // A request issued this cycle still returns next cycle; drop marks it stale.
      pc_n_s     = bus.redirect_pc;
      drop_n_s   = imem_req_s;
      count_n_s  = {CNT_W{1'b0}};
      rd_ptr_n_s = {PTR_W{1'b0}};
      wr_ptr_n_s = {PTR_W{1'b0}};
    end else begin
      if (imem_req_s) begin
        pc_n_s = pc_r + STEP_C;
      end else begin
        pc_n_s = pc_r;
      end

      if (push_s) begin
        wr_ptr_n_s = wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_n_s = wr_ptr_r;
      end

      if (pop_s) begin
        rd_ptr_n_s = rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_n_s = rd_ptr_r;
      end

      case ({push_s, pop_s})
        2'b10:   count_n_s = count_r + CNT_W'(1);
        2'b01:   count_n_s = count_r - CNT_W'(1);
        default: count_n_s = count_r;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clock or negedge r) begin
    if (!r) begin
      pc_r       <= RESET_PC_C;
      req_pc_r   <= {ADDR_W{1'b0}};
      inflight_r <= 1'b0;
      drop_r     <= 1'b0;
      count_r    <= {CNT_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
    end else begin
      pc_r       <= pc_n_s;
      req_pc_r   <= req_pc_n_s;
      inflight_r <= inflight_n_s;
      drop_r     <= drop_n_s;
      count_r    <= count_n_s;
      rd_ptr_r   <= rd_ptr_n_s;
      wr_ptr_r   <= wr_ptr_n_s;
    end
  end

  // FIFO storage, written with the returning instruction and its request PC.
  always_ff @(posedge clock or negedge r) begin
    if (!r) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_r[i] <= {INSTR_W{1'b0}};
        pc_mem_r[i]    <= {ADDR_W{1'b0}};
      end
    end else begin
      if (push_s) begin
        instr_mem_r[wr_ptr_r] <= bus.imem_data;
        pc_mem_r[wr_ptr_r]    <= req_pc_r;
      end
    end
  end

  // Outputs depend only on registered state (plus the reset gate on the request).
  always_comb begin
    bus.imem_req   = imem_req_s;
    bus.imem_addr  = pc_r;
    bus.out_valid  = valid_s;
    bus.fifo_count = count_r;
    if (valid_s) begin
      bus.out_instr = instr_mem_r[rd_ptr_r];
      bus.out_pc    = pc_mem_r[rd_ptr_r];
    end else begin
      bus.out_instr = {INSTR_W{1'b0}};
      bus.out_pc    = {ADDR_W{1'b0}};
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: an imem model, directed scenarios and a random
// phase, checked against the expected sequential PC stream from each start point.
module tb_fetch_unit;
  localparam int ADDR_W  = 9;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 3;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } item_t;

  logic clock = 1'b0;
  logic r     = 1'b0;

  fetch_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) bus ();

  fetch_unit #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .PC_STEP(1), .RESET_PC(0), .DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .r(r),
    .bus(bus)
  );

  always #5 clock = ~clock;

  logic [INSTR_W-1:0] imem [512];
  item_t              exp_q[$];
  int                 checks = 0;
  int                 fails  = 0;
  int                 pops   = 0;
  logic               req_q  = 1'b0;
  logic [ADDR_W-1:0]  addr_q = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected delivery after a (re)start: consecutive PCs, wrapping modulo 2^ADDR_W.
  function automatic void start_stream(input logic [ADDR_W-1:0] pc0);
    logic [ADDR_W-1:0] p;
    p = pc0;
    exp_q.delete();
    for (int i = 0; i < 2048; i++) begin
      exp_q.push_back({imem[p], p});
      p = p + ADDR_W'(1);
    end
  endfunction

  // Synchronous instruction memory: data for a request appears the following cycle.
  always @(negedge clock) begin
    req_q  = bus.imem_req;
    addr_q = bus.imem_addr;
  end

  always @(posedge clock) begin
    #1;
    bus.imem_data = req_q ? imem[addr_q] : $urandom();
  end

  // Monitor: pop the scoreboard on every handshake and check idle/full invariants.
  always @(negedge clock) begin
    if (r) begin
      check("count_le_depth", 64'(bus.fifo_count <= CNT_W'(DEPTH)), 64'(1));
      if (bus.fifo_count == CNT_W'(DEPTH)) begin
        check("no_req_when_full", 64'(bus.imem_req), 64'(0));
      end
      if (!bus.out_valid) begin
        check("idle_instr_zero", 64'(bus.out_instr), 64'(0));
        check("idle_pc_zero", 64'(bus.out_pc), 64'(0));
      end else if (bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 64'(1), 64'(0));
        end else begin
          item_t e;
          e = exp_q.pop_front();
          check("sb_pc", 64'(bus.out_pc), 64'(e.pc));
          check("sb_instr", 64'(bus.out_instr), 64'(e.instr));
          pops++;
        end
      end
    end
  end

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    @(negedge clock);
    while (!bus.out_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    check(name, 64'(bus.out_valid), 64'(1));
  endtask

  task automatic redirect_to(input logic [ADDR_W-1:0] target);
    @(posedge clock);
    #1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = target;
    @(posedge clock);
    #1;
    bus.redirect = 1'b0;
    start_stream(target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pops_before;
    logic [ADDR_W-1:0] rpc;

    for (int k = 0; k < 512; k++) begin
      imem[k] = (32'($urandom_range(0, 65535)) << 16) | 32'(k + 100);
    end
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready   = 1'b1;
    bus.imem_data   = '0;

    // Held in reset.
    #2;
    check("rst_req", 64'(bus.imem_req), 64'(0));
    check("rst_valid", 64'(bus.out_valid), 64'(0));
    check("rst_instr", 64'(bus.out_instr), 64'(0));
    check("rst_pc", 64'(bus.out_pc), 64'(0));
    check("rst_count", 64'(bus.fifo_count), 64'(0));

    // Release: sequential fetch from 0, first delivery two cycles after first request.
    repeat (2) @(posedge clock);
    start_stream('0);
    #2 r = 1'b1;
    @(negedge clock);
    check("c0_req", 64'(bus.imem_req), 64'(1));
    check("c0_addr", 64'(bus.imem_addr), 64'(0));
    check("c0_valid", 64'(bus.out_valid), 64'(0));
    @(negedge clock);
    check("c1_addr", 64'(bus.imem_addr), 64'(1));
    check("c1_valid", 64'(bus.out_valid), 64'(0));
    @(negedge clock);
    check("c2_addr", 64'(bus.imem_addr), 64'(2));
    check("c2_valid", 64'(bus.out_valid), 64'(1));
    check("c2_pc", 64'(bus.out_pc), 64'(0));
    check("c2_instr", 64'(bus.out_instr), 64'(imem[0]));
    repeat (4) @(posedge clock);

    // Backpressure: FIFO saturates, requests stop, then resume one cycle after a pop.
    #1 bus.out_ready = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    check("bp_count_full", 64'(bus.fifo_count), 64'(DEPTH));
    check("bp_req_off", 64'(bus.imem_req), 64'(0));
    @(posedge clock);
    #1 bus.out_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("bp_resume_req", 64'(bus.imem_req), 64'(1));
    check("bp_resume_count", 64'(bus.fifo_count), 64'(3));
    repeat (6) @(posedge clock);

    // Redirect while three instructions are queued.
    #1 bus.out_ready = 1'b0;
    n = 0;
    @(negedge clock);
    while (bus.fifo_count != CNT_W'(3) && n < 10) begin
      @(negedge clock);
      n++;
    end
    check("rd_reach_three", 64'(bus.fifo_count), 64'(3));
    #1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 9'h040;
    @(posedge clock);
    #1;
    bus.redirect = 1'b0;
    start_stream(9'h040);
    check("rd_flush_count", 64'(bus.fifo_count), 64'(0));
    check("rd_flush_valid", 64'(bus.out_valid), 64'(0));
    bus.out_ready = 1'b1;
    @(negedge clock);
    check("rd_lat0_valid", 64'(bus.out_valid), 64'(0));
    check("rd_lat0_addr", 64'(bus.imem_addr), 64'(9'h040));
    @(negedge clock);
    check("rd_lat1_valid", 64'(bus.out_valid), 64'(0));
    @(negedge clock);
    check("rd_lat2_valid", 64'(bus.out_valid), 64'(1));
    check("rd_lat2_pc", 64'(bus.out_pc), 64'(9'h040));
    repeat (5) @(posedge clock);

    // Back-to-back redirects: only the second target is delivered.
    @(posedge clock);
    #1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 9'h010;
    @(posedge clock);
    #1;
    bus.redirect_pc = 9'h020;
    start_stream(9'h010);
    @(posedge clock);
    #1;
    bus.redirect = 1'b0;
    start_stream(9'h020);
    wait_valid("b2b_valid");
    check("b2b_first_pc", 64'(bus.out_pc), 64'(9'h020));
    repeat (5) @(posedge clock);

    // PC wrap from the top of the address space.
    redirect_to(9'h1FE);
    wait_valid("wrap_valid");
    check("wrap_pc0", 64'(bus.out_pc), 64'(9'h1FE));
    @(negedge clock);
    check("wrap_pc1", 64'(bus.out_pc), 64'(9'h1FF));
    @(negedge clock);
    check("wrap_pc2", 64'(bus.out_pc), 64'(9'h000));
    @(negedge clock);
    check("wrap_pc3", 64'(bus.out_pc), 64'(9'h001));
    repeat (3) @(posedge clock);

    // Asynchronous reset in the middle of a stream.
    @(posedge clock);
    #3 r = 1'b0;
    #1;
    check("arst_valid", 64'(bus.out_valid), 64'(0));
    check("arst_instr", 64'(bus.out_instr), 64'(0));
    check("arst_pc", 64'(bus.out_pc), 64'(0));
    check("arst_count", 64'(bus.fifo_count), 64'(0));
    check("arst_req", 64'(bus.imem_req), 64'(0));
    repeat (2) @(posedge clock);
    start_stream('0);
    #2 r = 1'b1;
    @(negedge clock);
    check("arst_restart_addr", 64'(bus.imem_addr), 64'(0));
    wait_valid("arst_restart_valid");
    check("arst_restart_pc", 64'(bus.out_pc), 64'(0));

    // Random backpressure and redirects.
    pops_before = pops;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clock);
      #1;
      bus.out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 31) == 0) begin
        rpc             = ADDR_W'($urandom());
        bus.redirect    = 1'b1;
        bus.redirect_pc = rpc;
        @(posedge clock);
        #1;
        bus.redirect = 1'b0;
        start_stream(rpc);
      end
    end
    check("rand_progress", 64'((pops - pops_before) > 500), 64'(1));

    @(posedge clock);
    #1 bus.out_ready = 1'b0;
    repeat (2) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
